// File: rtl/reg_cmd_sequencer.sv
// Command sequencer driving a 16-bit target register's FunSel/E/I inputs, one command at a time.
// Optional `REG_SHADOW_EN adds a Shadow output that mirrors the target register value.
module reg_cmd_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [2:0]  CmdOp,
    input  logic [15:0] CmdData,
    input  logic        ByteValid,
    input  logic [7:0]  ByteIn,
    output logic        ByteReady,
    output logic [2:0]  FunSel,
    output logic        E,
    output logic [15:0] I,
    output logic        Busy,
    output logic        Done,
    output logic        Err
`ifdef REG_SHADOW_EN
    ,
    output logic [15:0] Shadow
`endif
);

    localparam logic [2:0] OP_DEC       = 3'b000;
    localparam logic [2:0] OP_INC       = 3'b001;
    localparam logic [2:0] OP_LOAD      = 3'b010;
    localparam logic [2:0] OP_CLR       = 3'b011;
    localparam logic [2:0] OP_LOADBYTES = 3'b100;
    localparam logic [2:0] OP_SEXT      = 3'b101;
    localparam logic [2:0] OP_REPINC    = 3'b110;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, REPEAT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funsel_q, funsel_d;
    logic        e_q, e_d;
    logic [15:0] i_q, i_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cmd_ready_q, byte_ready_q, busy_q;

    // Outputs are computed here for the next cycle and registered, so a pulse appears the cycle after its trigger.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funsel_d = 3'b000;
        e_d      = 1'b0;
        i_d      = 16'h0000;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    case (CmdOp)
                        OP_DEC, OP_INC, OP_CLR: begin
                            e_d      = 1'b1;
                            funsel_d = CmdOp;
                            done_d   = 1'b1;
                            state_d  = ISSUE;
                        end
                        OP_LOAD: begin
                            e_d      = 1'b1;
                            funsel_d = 3'b010;
                            i_d      = CmdData;
                            done_d   = 1'b1;
                            state_d  = ISSUE;
                        end
                        OP_SEXT: begin
                            e_d      = 1'b1;
                            funsel_d = 3'b111;
                            i_d      = {8'h00, CmdData[7:0]};
                            done_d   = 1'b1;
                            state_d  = ISSUE;
                        end
                        OP_LOADBYTES: state_d = WAIT_LO;
                        OP_REPINC: begin
                            if (CmdData[7:0] == 8'd0) begin
                                done_d  = 1'b1;
                                state_d = ISSUE;
                            end else begin
                                e_d      = 1'b1;
                                funsel_d = 3'b001;
                                cnt_d    = CmdData[7:0] - 8'd1;
                                done_d   = (CmdData[7:0] == 8'd1);
                                state_d  = (CmdData[7:0] == 8'd1) ? ISSUE : REPEAT;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = ISSUE;
                        end
                    endcase
                end
            end
            ISSUE: state_d = IDLE;
            WAIT_LO: begin
                if (ByteValid) begin
                    e_d      = 1'b1;
                    funsel_d = 3'b100;
                    i_d      = {8'h00, ByteIn};
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (ByteValid) begin
                    e_d      = 1'b1;
                    funsel_d = 3'b110;
                    i_d      = {ByteIn, 8'h00};
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            REPEAT: begin
                // cnt_q holds the pulses still owed, including this one.
                e_d      = 1'b1;
                funsel_d = 3'b001;
                cnt_d    = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            funsel_q     <= 3'b000;
            e_q          <= 1'b0;
            i_q          <= 16'h0000;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funsel_q     <= funsel_d;
            e_q          <= e_d;
            i_q          <= i_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cmd_ready_q  <= (state_d == IDLE);
            byte_ready_q <= (state_d == WAIT_LO) || (state_d == WAIT_HI);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign CmdReady  = cmd_ready_q;
    assign ByteReady = byte_ready_q;
    assign FunSel    = funsel_q;
    assign E         = e_q;
    assign I         = i_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;

`ifdef REG_SHADOW_EN
    logic [15:0] shadow_q;

    function automatic logic [15:0] shadow_next(input logic [15:0] cur, input logic [2:0] fs,
                                                input logic [15:0] val);
        case (fs)
            3'b000:  return cur - 16'd1;
            3'b001:  return cur + 16'd1;
            3'b010:  return val;
            3'b011:  return 16'h0000;
            3'b100:  return {8'h00, val[7:0]};
            3'b110:  return {val[15:8], cur[7:0]};
            3'b111:  return {{8{val[7]}}, val[7:0]};
            default: return cur;
        endcase
    endfunction

    // Updated alongside the registered E pulse, so it already shows the value the target will hold.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shadow_q <= 16'h0000;
        end else if (e_d) begin
            shadow_q <= shadow_next(shadow_q, funsel_d, i_d);
        end
    end

    assign Shadow = shadow_q;
`endif

endmodule
